mc_controller: RTL
==================

Name: mc_controller

Overview:
- Multicycle main-control FSM for the core datapath; the producer side of the ALU control interface.
- Decodes op/funct and drives the 3-bit ALU control code (F). Consumes the ALU Zero flag for branches.
- Sequences fetch/decode/execute/memory/writeback and drives all datapath enables and mux selects.
- Stalls on a ready/request memory handshake.

Parameters:
- RESET_STATE_FETCH, 1, 1 = reset enters FETCH; 0 = reset enters a one-cycle IDLE state before FETCH.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- op  in  6  instruction[31:26] from IR
- funct  in  6  instruction[5:0] from IR
- zero  in  1  ALU Zero flag, same cycle as alucontrol
- mem_ready  in  1  memory accepted/completed the access this cycle
- mem_req  out  1  memory access request
- iord  out  1  0 = address from PC, 1 = address from ALUOut
- memwrite  out  1  memory write strobe (qualified by mem_req)
- irwrite  out  1  instruction register load
- regdst  out  1  1 = rd, 0 = rt
- memtoreg  out  1  1 = writeback from data register
- regwrite  out  1  register file write
- alusrca  out  1  0 = PC, 1 = register A
- alusrcb  out  2  00 = B, 01 = const 4, 10 = signimm, 11 = signimm<<2
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- pcen  out  1  PC load enable
- alucontrol  out  3  ALU F code
- illegal_op  out  1  one-cycle pulse in DECODE on an unsupported op or funct

Behaviour:
- ALU F codes: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- R-type funct mapping: 100000→ADD, 100010→SUB, 100100→AND, 100101→OR, 101010→SLT.
- Unknown funct → ADD and illegal_op.
- Reset (asynchronous): state ← FETCH (or IDLE per parameter).
  - While reset is high: mem_req, memwrite, irwrite, regwrite, pcen and illegal_op are forced to 0.
  - All selects are 0; alucontrol = 010.
- Outputs are Moore decodes of state, except pcen, which also depends on zero combinationally. Unlisted outputs are 0 in each state.
- FETCH: mem_req = 1, iord = 0, alusrca = 0, alusrcb = 01, ADD, pcsrc = 00.
  - irwrite and pcen are asserted only when mem_ready = 1; the FSM then goes to DECODE.
  - With mem_ready = 0 it stays in FETCH.
- DECODE: alusrca = 0, alusrcb = 11, ADD (branch target into ALUOut).
  - Next state: lw/sw → MEMADR; R-type → RTYPEEX; beq → BEQEX; addi → ADDIEX; j → JEX.
  - Unknown op → FETCH, with illegal_op = 1 for this cycle.
- MEMADR: alusrca = 1, alusrcb = 10, ADD. Next: lw → MEMRD, sw → MEMWR.
- MEMRD: mem_req = 1, iord = 1. Holds until mem_ready = 1, then → MEMWB.
- MEMWB: regdst = 0, memtoreg = 1, regwrite = 1 → FETCH.
- MEMWR: mem_req = 1, iord = 1, memwrite = 1, all held while waiting. On mem_ready = 1 → FETCH.
- RTYPEEX: alusrca = 1, alusrcb = 00, alucontrol from funct → RTYPEWB.
- RTYPEWB: regdst = 1, memtoreg = 0, regwrite = 1 → FETCH.
- BEQEX: alusrca = 1, alusrcb = 00, SUB, pcsrc = 01; pcen = zero → FETCH.
- ADDIEX: alusrca = 1, alusrcb = 10, ADD → ADDIWB.
- ADDIWB: regdst = 0, memtoreg = 0, regwrite = 1 → FETCH.
- JEX: pcsrc = 10, pcen = 1 → FETCH.
- Reset mid-access: mem_req drops immediately (asynchronously); no partial write completes.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- The IR is stable outside FETCH; op/funct are sampled only in DECODE, RTYPEEX and MEMADR.

Optional Feature:
- Macro BNE_EN.
- Defined: op 000101 (bne) is legal. DECODE → BNEEX, which is identical to BEQEX except pcen = ~zero.
- Undefined: op 000101 is unknown; it raises illegal_op and returns to FETCH.

Decomposition:
- Package ctrl_pkg holds:
  - Opcode and funct localparams and the ALU F-code localparams.
  - The state enum typedef (logic [3:0]) and the aluop typedef: 00 ADD, 01 SUB, 10 use funct.
- Sub-module alu_dec: combinational (aluop, funct) → alucontrol and funct_illegal.
- mc_controller holds the state register, next-state logic and output decode.

Test Plan:
- lw, mem_ready low 2 cycles in FETCH and 3 in MEMRD → state path FETCH×3, DECODE, MEMADR, MEMRD×4, MEMWB. irwrite/pcen pulse exactly once; regwrite = 1 and memtoreg = 1 only in MEMWB.
- R-type funct 100010 → alucontrol = 110 in RTYPEEX; regdst = 1 and regwrite = 1 in RTYPEWB; total 4 cycles with mem_ready tied 1.
- beq with zero = 1 then zero = 0 → pcen = 1, pcsrc = 01 in BEQEX; then pcen = 0. Both runs return to FETCH.
- sw with reset asserted mid-MEMWR (async, between clock edges) → memwrite and mem_req fall the same instant; state = FETCH after release.
- op 111111, and R-type funct 000111 → illegal_op single-cycle pulse; regwrite never asserted for the op case.
- With BNE_EN: op 000101, zero = 0 → pcen = 1; without BNE_EN → illegal_op = 1 in DECODE.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: opcodes, R-type functs, ALU F codes,
// FSM state and ALU-op types. The optional bne support is enabled with the BNE_EN macro.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // S_BNEEX is only reachable when BNE_EN is defined; S_IDLE only when reset skips FETCH.
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_BNEEX   = 4'd12,
    S_IDLE    = 4'd13
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  function automatic logic isMemOp(input logic [5:0] opcode);
    return (opcode == OP_LW) || (opcode == OP_SW);
  endfunction

endpackage

// File: rtl/mc_controller_alu_dec.sv
// ALU decoder: maps (aluop, funct) to the 3-bit ALU F code.
// funct_illegal_o flags an unsupported funct regardless of aluop so DECODE can report it early.
module alu_dec
  import ctrl_pkg::*;
(
  input  aluop_t      aluop_i,
  input  logic [5:0]  funct_i,
  output logic [2:0]  alucontrol_o,
  output logic        funct_illegal_o
);

  logic [2:0] functCode;

  always_comb begin
    functCode       = ALU_ADD;
    funct_illegal_o = 1'b0;
    case (funct_i)
      FUNCT_ADD: functCode = ALU_ADD;
      FUNCT_SUB: functCode = ALU_SUB;
      FUNCT_AND: functCode = ALU_AND;
      FUNCT_OR:  functCode = ALU_OR;
      FUNCT_SLT: functCode = ALU_SLT;
      default:   funct_illegal_o = 1'b1;
    endcase
  end

  always_comb begin
    alucontrol_o = ALU_ADD;
    case (aluop_i)
      ALUOP_SUB:   alucontrol_o = ALU_SUB;
      ALUOP_FUNCT: alucontrol_o = functCode;
      default:     alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle main-control FSM: sequences fetch/decode/execute/memory/writeback and drives
// datapath enables and selects. Define BNE_EN to add bne support (BNEEX state).
module mc_controller
  import ctrl_pkg::*;
#(
  parameter logic RESET_STATE_FETCH = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [2:0] alucontrol,
  output logic       illegal_op
);

  localparam state_t RESET_STATE = (RESET_STATE_FETCH != 1'b0) ? S_FETCH : S_IDLE;

  state_t state_q;
  state_t state_d;
  aluop_t aluOp;
  logic   functIllegal;
  logic   opLegal;

  alu_dec u_alu_dec (
    .aluop_i        (aluOp),
    .funct_i        (funct),
    .alucontrol_o   (alucontrol),
    .funct_illegal_o(functIllegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RESET_STATE;
    else       state_q <= state_d;
  end

  always_comb begin
    opLegal = 1'b0;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: opLegal = 1'b1;
`ifdef BNE_EN
      OP_BNE: opLegal = 1'b1;
`endif
      default: opLegal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (isMemOp(op)) begin
          state_d = S_MEMADR;
        end else begin
          case (op)
            OP_RTYPE: state_d = S_RTYPEEX;
            OP_BEQ:   state_d = S_BEQEX;
            OP_ADDI:  state_d = S_ADDIEX;
            OP_J:     state_d = S_JEX;
`ifdef BNE_EN
            OP_BNE:   state_d = S_BNEEX;
`endif
            default:  state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:   if (mem_ready) state_d = S_FETCH;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_MEMWB, S_RTYPEWB, S_ADDIWB, S_BEQEX, S_BNEEX, S_JEX: state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  // Moore decode of state; pcen also follows mem_ready/zero combinationally.
  // Reset overrides everything so mem_req drops the instant reset rises.
  always_comb begin
    mem_req    = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    pcen       = 1'b0;
    illegal_op = 1'b0;
    aluOp      = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcen    = mem_ready;
      end
      S_DECODE: begin
        alusrcb    = 2'b11;
        illegal_op = ~opLegal | ((op == OP_RTYPE) & functIllegal);
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluOp   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BEQEX, S_BNEEX: begin
        alusrca = 1'b1;
        aluOp   = ALUOP_SUB;
        pcsrc   = 2'b01;
        pcen    = (state_q == S_BNEEX) ? ~zero : zero;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JEX: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      mem_req    = 1'b0;
      iord       = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      pcen       = 1'b0;
      illegal_op = 1'b0;
      aluOp      = ALUOP_ADD;
    end
  end

endmodule
